// File: rtl/find_extrema_pipe.sv
// find_extrema_pipe: pipelined max/min finder with argmax/argmin and range.
// Two registered comparator trees; lower channel index wins ties in both trees.
module find_extrema_pipe #(
    parameter int WIDTH  = 10,
    parameter int NUM_CH = 3,
    parameter bit SIGNED = 1'b0,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        max_val,
    output logic [IDX_W-1:0]        max_idx,
    output logic [WIDTH-1:0]        min_val,
    output logic [IDX_W-1:0]        min_idx,
    output logic [WIDTH:0]          range
);
    localparam int LV = $clog2(NUM_CH);

    function automatic logic ge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return SIGNED ? ($signed(a) >= $signed(b)) : (a >= b);
    endfunction

    function automatic logic le(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return SIGNED ? ($signed(a) <= $signed(b)) : (a <= b);
    endfunction

    // node count feeding level l
    function automatic int cnt(input int l);
        return (NUM_CH + (1 << l) - 1) >> l;
    endfunction

    // one spare slot per level lets the odd pass-through read index NUM_CH safely
    logic [WIDTH-1:0] w_mx  [LV][NUM_CH+1];
    logic [WIDTH-1:0] w_mn  [LV][NUM_CH+1];
    logic [IDX_W-1:0] w_mxi [LV][NUM_CH+1];
    logic [IDX_W-1:0] w_mni [LV][NUM_CH+1];
    logic [WIDTH-1:0] w_nmx [LV][NUM_CH];
    logic [WIDTH-1:0] w_nmn [LV][NUM_CH];
    logic [IDX_W-1:0] w_nmxi[LV][NUM_CH];
    logic [IDX_W-1:0] w_nmni[LV][NUM_CH];
    logic [WIDTH-1:0] r_mx  [LV][NUM_CH];
    logic [WIDTH-1:0] r_mn  [LV][NUM_CH];
    logic [IDX_W-1:0] r_mxi [LV][NUM_CH];
    logic [IDX_W-1:0] r_mni [LV][NUM_CH];
    logic [LV:0]      r_vld;
    logic [WIDTH:0]   w_emx;
    logic [WIDTH:0]   w_emn;

    always_comb begin
        for (int l = 0; l < LV; l++) begin
            for (int j = 0; j <= NUM_CH; j++) begin
                w_mx[l][j]  = '0;
                w_mn[l][j]  = '0;
                w_mxi[l][j] = '0;
                w_mni[l][j] = '0;
            end
            for (int j = 0; j < NUM_CH; j++) begin
                w_nmx[l][j]  = '0;
                w_nmn[l][j]  = '0;
                w_nmxi[l][j] = '0;
                w_nmni[l][j] = '0;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            w_mx[0][j]  = in_data[j*WIDTH +: WIDTH];
            w_mn[0][j]  = in_data[j*WIDTH +: WIDTH];
            w_mxi[0][j] = IDX_W'(j);
            w_mni[0][j] = IDX_W'(j);
        end
        for (int l = 1; l < LV; l++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                w_mx[l][j]  = r_mx[l-1][j];
                w_mn[l][j]  = r_mn[l-1][j];
                w_mxi[l][j] = r_mxi[l-1][j];
                w_mni[l][j] = r_mni[l-1][j];
            end
        end
        for (int l = 0; l < LV; l++) begin
            for (int j = 0; j < (NUM_CH + 1) / 2; j++) begin
                if (2*j + 1 < cnt(l)) begin
                    w_nmx[l][j]  = ge(w_mx[l][2*j], w_mx[l][2*j+1]) ? w_mx[l][2*j]  : w_mx[l][2*j+1];
                    w_nmxi[l][j] = ge(w_mx[l][2*j], w_mx[l][2*j+1]) ? w_mxi[l][2*j] : w_mxi[l][2*j+1];
                    w_nmn[l][j]  = le(w_mn[l][2*j], w_mn[l][2*j+1]) ? w_mn[l][2*j]  : w_mn[l][2*j+1];
                    w_nmni[l][j] = le(w_mn[l][2*j], w_mn[l][2*j+1]) ? w_mni[l][2*j] : w_mni[l][2*j+1];
                end else if (2*j < cnt(l)) begin
                    w_nmx[l][j]  = w_mx[l][2*j];
                    w_nmxi[l][j] = w_mxi[l][2*j];
                    w_nmn[l][j]  = w_mn[l][2*j];
                    w_nmni[l][j] = w_mni[l][2*j];
                end
            end
        end
    end

    assign w_emx = SIGNED ? {r_mx[LV-1][0][WIDTH-1], r_mx[LV-1][0]} : {1'b0, r_mx[LV-1][0]};
    assign w_emn = SIGNED ? {r_mn[LV-1][0][WIDTH-1], r_mn[LV-1][0]} : {1'b0, r_mn[LV-1][0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mx      <= '{default: '0};
            r_mn      <= '{default: '0};
            r_mxi     <= '{default: '0};
            r_mni     <= '{default: '0};
            r_vld     <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            min_val   <= '0;
            min_idx   <= '0;
            range     <= '0;
        end else if (ce) begin
            r_mx      <= w_nmx;
            r_mn      <= w_nmn;
            r_mxi     <= w_nmxi;
            r_mni     <= w_nmni;
            r_vld     <= {r_vld[LV-1:0], in_valid};
            max_val   <= r_mx[LV-1][0];
            max_idx   <= r_mxi[LV-1][0];
            min_val   <= r_mn[LV-1][0];
            min_idx   <= r_mni[LV-1][0];
            range     <= w_emx - w_emn;
        end
    end

    assign out_valid = r_vld[LV];
endmodule
